// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and sizing helpers for the digit-serial add/sub unit
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;

  function automatic int ndig(input int width);
    return (width + DIGIT_W - 1) / DIGIT_W;
  endfunction

endpackage

// File: rtl/adder4_slice.sv
// rtl/adder4_slice.sv - 4-bit ripple adder slice, behaviourally a 74AC283
module adder4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
  assign s   = sum[3:0];
  assign co  = sum[4];

endmodule

// File: rtl/digit_serial_addsub.sv
// rtl/digit_serial_addsub.sv - add/subtract over WIDTH bits, one 4-bit digit per clock
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NDIG = ndig(WIDTH);
  localparam int PW   = NDIG * DIGIT_W;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [PW-1:0] a_q, b_q, res_q, res_next;
  logic [WIDTH-1:0] b_eff;
  logic carry_q, sub_q, signed_q, a_msb_q, b_msb_q, cout_q, ovf_q;
  logic [3:0] slice_s;
  logic slice_co, accept, last_digit, cout_next, ovf_next;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          in_ready   = 1'b1;
          state_next = in_valid ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_valid  = (state == DONE);
  assign accept     = in_valid & in_ready;
  assign last_digit = (state == RUN) && (cnt == LAST);
  assign b_eff      = in_sub ? ~in_b : in_b;

  adder4_slice u_slice (
    .a  (a_q[3:0]),
    .b  (b_q[3:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Each sum nibble enters at the top, so after NDIG shifts digit k sits at position k.
  assign res_next = (res_q >> DIGIT_W) | (PW'(slice_s) << (PW - DIGIT_W));

  if (WIDTH % DIGIT_W == 0) begin : g_full
    assign cout_next = slice_co;
  end else begin : g_pad
    assign cout_next = res_next[WIDTH];
  end

  assign ovf_next = signed_q ? ((a_msb_q ~^ b_msb_q) & (res_next[WIDTH-1] ^ a_msb_q))
                             : (sub_q ? ~cout_next : cout_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      signed_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q      <= PW'(in_a);
        b_q      <= PW'(b_eff);
        carry_q  <= in_sub;
        sub_q    <= in_sub;
        signed_q <= in_signed;
        a_msb_q  <= in_a[WIDTH-1];
        b_msb_q  <= b_eff[WIDTH-1];
        cnt      <= '0;
      end else if (state == RUN) begin
        a_q     <= a_q >> DIGIT_W;
        b_q     <= b_q >> DIGIT_W;
        res_q   <= res_next;
        carry_q <= slice_co;
        cnt     <= last_digit ? '0 : cnt + 1'b1;
        if (last_digit) begin
          cout_q <= cout_next;
          ovf_q  <= ovf_next;
        end
      end
    end
  end

  assign out_y    = res_q[WIDTH-1:0];
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb/tb_digit_serial_addsub.sv - scoreboard bench over several operand widths
module tb_digit_serial_addsub;

  localparam int NW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit done_a [NW];

  function automatic int width_of(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      2:       return 5;
      3:       return 6;
      4:       return 16;
      default: return 33;
    endcase
  endfunction

  // Full-precision arithmetic reference: {y[63:0], cout, ovf}
  function automatic logic [65:0] model(input int w, input longint unsigned a, input longint unsigned b,
                                        input bit sub, input bit sgn);
    longint unsigned mask, ua, ub, r;
    longint sa, sb, sr, lim;
    bit c, v;
    mask = (64'd1 << w) - 64'd1;
    ua   = a & mask;
    ub   = b & mask;
    if (sub) begin
      r = ua - ub;
      c = (ua >= ub);
    end else begin
      r = ua + ub;
      c = r[w];
    end
    sa  = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb  = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    sr  = sub ? sa - sb : sa + sb;
    lim = longint'(64'd1 << (w - 1));
    v   = sgn ? ((sr >= lim) || (sr < -lim)) : (sub ? !c : c);
    return {r & mask, c, v};
  endfunction

  function automatic longint unsigned pick(input int w);
    longint unsigned r;
    case ($urandom_range(0, 5))
      0:       r = 64'd0;
      1:       r = '1;
      2:       r = 64'd1 << (w - 1);
      3:       r = (64'd1 << (w - 1)) - 64'd1;
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  task automatic check(input string name, input int w, input logic [66:0] act, input logic [66:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s W=%0d actual=%0h required=%0h", name, w, act, exp);
    end
  endtask

  for (genvar g = 0; g < NW; g++) begin : g_unit
    localparam int W = width_of(g);
    localparam int NDIG_M = (W + 3) / 4;

    logic rst_n, in_valid, in_ready, in_sub, in_signed, out_valid, out_ready, out_cout, out_ovf;
    logic [W-1:0] in_a, in_b, out_y;
    logic [65:0] exp_q[$];
    int ready_mode = 0;

    digit_serial_addsub #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .in_signed (in_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
    );

    initial begin : consumer
      out_ready = 1'b0;
      forever begin
        @(negedge clk);
        case (ready_mode)
          1:       out_ready = 1'b0;
          2:       out_ready = 1'b1;
          default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
      end
    end

    initial begin : monitor
      logic [65:0] saved, got;
      bit held;
      held  = 1'b0;
      saved = '0;
      forever begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
          held = 1'b0;
        end else begin
          got = {64'(out_y), out_cout, out_ovf};
          if (held) check("hold_stable", W, {out_valid, got}, {1'b1, saved});
          if (out_valid && !out_ready) begin
            check("in_ready_hold", W, 67'(in_ready), 67'(0));
            saved = got;
            held  = 1'b1;
          end else begin
            held = 1'b0;
          end
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", W, 67'(out_valid), 67'(0));
            else check("result", W, 67'(got), 67'(exp_q.pop_front()));
          end
        end
      end
    end

    task automatic send(input longint unsigned a, input longint unsigned b, input bit sub, input bit sgn,
                        output int tries);
      @(negedge clk);
      in_a      = W'(a);
      in_b      = W'(b);
      in_sub    = sub;
      in_signed = sgn;
      in_valid  = 1'b1;
      #2;
      tries = 0;
      while (!in_ready && tries < 200) begin
        @(negedge clk);
        #2;
        tries++;
      end
      if (!in_ready) begin
        check("accept_timeout", W, 67'(in_ready), 67'(1));
        in_valid = 1'b0;
      end else begin
        exp_q.push_back(model(W, a, b, sub, sgn));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    endtask

    task automatic drain();
      for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
      if (exp_q.size() != 0) check("drain_timeout", W, 67'(exp_q.size()), 67'(0));
    endtask

    initial begin : driver
      int tries, lat;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      in_signed = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_state", W, 67'({out_valid, in_ready, out_cout, out_ovf, 40'(out_y)}),
            67'({4'b0100, 40'd0}));
      @(negedge clk);
      rst_n = 1'b1;

      if (W == 16) begin
        send(64'h7FFF, 64'h0001, 1'b0, 1'b1, tries);
        lat = 1;
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          #2;
          if (out_valid) break;
          lat++;
        end
        check("latency", W, 67'(lat), 67'(NDIG_M + 1));
        send(64'h0000, 64'h0001, 1'b1, 1'b0, tries);
        send(64'h0005, 64'h0003, 1'b1, 1'b0, tries);

        // Hold the result under backpressure, then release and issue a new op on the same cycle.
        drain();
        ready_mode = 1;
        send(pick(W), pick(W), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tries);
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          #2;
          if (out_valid) break;
        end
        repeat (10) @(negedge clk);
        ready_mode = 2;
        send(pick(W), pick(W), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tries);
        check("b2b_accept", W, 67'(tries), 67'(0));
        ready_mode = 0;

        drain();
        send(64'hABCD, 64'h1234, 1'b0, 1'b0, tries);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("reset_mid_run", W, 67'({out_valid, in_ready, out_cout, out_ovf, 40'(out_y)}),
              67'({4'b0100, 40'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        send(64'h1234, 64'h0FFF, 1'b1, 1'b1, tries);
      end

      if (W == 6) send(64'h3F, 64'h01, 1'b0, 1'b0, tries);

      for (int i = 0; i < 60; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(pick(W), pick(W), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tries);
      end
      drain();
      done_a[g] = 1'b1;
    end
  end

  initial begin : finisher
    bit all_done;
    all_done = 1'b0;
    for (int t = 0; t < 20000 && !all_done; t++) begin
      @(posedge clk);
      all_done = 1'b1;
      foreach (done_a[i]) if (!done_a[i]) all_done = 1'b0;
    end
    if (!all_done) check("global_timeout", 0, 67'(all_done), 67'(1));
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
